// File: rtl/bb_pkg.sv
// Shared types and constants for the halt-result UART reporter.
// Holds the FSM state enum, ASCII constants and a nibble-to-hex helper.
package bb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        SEND,
        DONE
    } state_e;

    localparam logic [7:0] ASC_0  = 8'h30;
    localparam logic [7:0] ASC_X  = 8'h78;
    localparam logic [7:0] ASC_A  = 8'h41;
    localparam logic [7:0] ASC_CR = 8'h0D;
    localparam logic [7:0] ASC_LF = 8'h0A;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return ASC_0 + {4'd0, nib};
        end
        return ASC_A + {4'd0, nib} - 8'd10;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer with valid/ready handshake; DIV clocks per bit.
// Ports: clk, reset, valid, data[7:0] in; ready, last, tx out.
module uart_tx_byte #(
    parameter int DIV = 572
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       last,
    output logic       tx
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    logic          active_q, active_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [9:0]    frame_q, frame_d;
    logic          bit_end;

    assign bit_end = active_q && (cnt_q == CNT_MAX);
    // final cycle of the stop bit
    assign last    = bit_end && (bit_q == 4'd9);
    // accepting during the last stop-bit cycle keeps frames back-to-back
    assign ready   = !active_q || last;
    // ones shift in behind the frame, so the line idles high
    assign tx      = frame_q[0];

    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        frame_d  = frame_q;
        if (active_q) begin
            if (bit_end) begin
                cnt_d   = '0;
                bit_d   = bit_q + 4'd1;
                frame_d = {1'b1, frame_q[9:1]};
                if (last) begin
                    active_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        if (valid && ready) begin
            active_d = 1'b1;
            cnt_d    = '0;
            bit_d    = 4'd0;
            frame_d  = {1'b1, data, 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            bit_q    <= 4'd0;
            frame_q  <= '1;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            frame_q  <= frame_d;
        end
    end

endmodule

// File: rtl/bb_result_uart.sv
// Counts Turing-machine steps and reports the count over UART on halt.
// Ports: CLK_66MHZ, reset, run, halt in; tx, busy, count, overflow out.
module bb_result_uart #(
    parameter int CLK_HZ = 66000000,
    parameter int BAUD   = 115200,
    parameter int CNT_W  = 36
) (
    input  logic             CLK_66MHZ,
    input  logic             reset,
    input  logic             run,
    input  logic             halt,
    output logic             tx,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    import bb_pkg::*;

    localparam int DIV = CLK_HZ / BAUD;
    localparam int NH  = CNT_W / 4;
    localparam int NB  = NH + 4;
    localparam int IW  = $clog2(NB + 1);
    localparam logic [CNT_W-1:0] ONES = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] snap_q, snap_d;
    logic             ovf_q, ovf_d;
    logic             halt_q, halt_d;
    logic [IW-1:0]    idx_q, idx_d;

    logic       step;
    logic       halt_rise;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_last;
    logic [7:0] tx_byte;
    logic [3:0] nib;

    assign step      = run && !halt;
    assign halt_rise = halt && !halt_q;
    assign tx_valid  = (state_q == SEND) && (idx_q < IW'(NB));
    assign busy      = (state_q == SEND);
    assign count     = count_q;
    assign overflow  = ovf_q;

    // message byte for the current index: "0x", hex digits, CR, LF
    always_comb begin
        nib = 4'd0;
        for (int i = 0; i < NH; i++) begin
            if (idx_q == IW'(i + 2)) begin
                nib = snap_q[4*(NH-1-i) +: 4];
            end
        end
        tx_byte = hex_ascii(nib);
        if (idx_q == IW'(0)) begin
            tx_byte = ASC_0;
        end else if (idx_q == IW'(1)) begin
            tx_byte = ASC_X;
        end else if (idx_q == IW'(NB - 2)) begin
            tx_byte = ASC_CR;
        end else if (idx_q == IW'(NB - 1)) begin
            tx_byte = ASC_LF;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        snap_d  = snap_q;
        ovf_d   = ovf_q;
        idx_d   = idx_q;
        halt_d  = halt;
        unique case (state_q)
            IDLE, COUNT: begin
                // a halt edge wins over a step in the same cycle
                if (halt_rise) begin
                    snap_d  = count_q;
                    idx_d   = '0;
                    state_d = SEND;
                end else if (step) begin
                    state_d = COUNT;
                    if (count_q != ONES) begin
                        count_d = count_q + CNT_W'(1);
                    end
                    if (count_d == ONES) begin
                        ovf_d = 1'b1;
                    end
                end
            end
            SEND: begin
                if (tx_valid && tx_ready) begin
                    idx_d = idx_q + IW'(1);
                end
                if (tx_last && (idx_q == IW'(NB))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!halt) begin
                    state_d = IDLE;
                    count_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_66MHZ) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            snap_q  <= '0;
            ovf_q   <= 1'b0;
            halt_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            snap_q  <= snap_d;
            ovf_q   <= ovf_d;
            halt_q  <= halt_d;
            idx_q   <= idx_d;
        end
    end

    uart_tx_byte #(
        .DIV(DIV)
    ) u_tx (
        .clk  (CLK_66MHZ),
        .reset(reset),
        .valid(tx_valid),
        .data (tx_byte),
        .ready(tx_ready),
        .last (tx_last),
        .tx   (tx)
    );

endmodule

// File: tb/tb_bb_result_uart.sv
// Directed bench for bb_result_uart at 16 clocks per bit.
// Two instances: 36-bit counter and 8-bit counter for saturation.
module tb_bb_result_uart;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, run, halt, run8, halt8;
    logic        tx, busy, overflow;
    logic [35:0] count;
    logic        tx8, busy8, ovf8;
    logic [7:0]  count8;

    int ncmp  = 0;
    int nfail = 0;
    int cyc   = 0;
    int t0;
    logic sel8 = 1'b0;
    logic rx_line, busy_line;

    assign rx_line   = sel8 ? tx8 : tx;
    assign busy_line = sel8 ? busy8 : busy;

    always @(posedge clk) cyc <= cyc + 1;

    bb_result_uart #(.CLK_HZ(16), .BAUD(1), .CNT_W(36)) dut (
        .CLK_66MHZ(clk), .reset(reset), .run(run), .halt(halt),
        .tx(tx), .busy(busy), .count(count), .overflow(overflow)
    );

    bb_result_uart #(.CLK_HZ(16), .BAUD(1), .CNT_W(8)) dut8 (
        .CLK_66MHZ(clk), .reset(reset), .run(run8), .halt(halt8),
        .tx(tx8), .busy(busy8), .count(count8), .overflow(ovf8)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rx_byte(output logic [7:0] b, output int tfall);
        int n;
        n = 0;
        b = 'x;
        tfall = cyc;
        while (rx_line !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            check("rx_timeout", 64'(n < 400), 1);
            return;
        end
        tfall = cyc;
        step(8);
        check("start_bit", rx_line, 0);
        for (int i = 0; i < 8; i++) begin
            step(16);
            b[i] = rx_line;
        end
        step(16);
        check("stop_bit", rx_line, 1);
    endtask

    task automatic expect_msg(input string tag, input string s,
                              output int tfirst);
        logic [7:0] b;
        int t;
        tfirst = 0;
        for (int i = 0; i < s.len(); i++) begin
            rx_byte(b, t);
            if (i == 0) tfirst = t;
            if (i == 1) check({tag, "_gap"}, 64'(t - tfirst), 160);
            check(tag, b, s[i]);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_line === 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 64'(n < 300), 1);
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; halt = 1'b0;
        run8 = 1'b0; halt8 = 1'b0;
        step(3);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_count", count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_count8", count8, 0);
        reset = 1'b0;

        // ten steps then halt
        run = 1'b1;
        step(10);
        run = 1'b0;
        check("run_count", count, 10);
        check("run_busy", busy, 0);
        halt = 1'b1;
        @(negedge clk);
        check("send_busy", busy, 1);
        check("send_count", count, 10);
        expect_msg("msg_run", "0x00000000A\015\012", t0);
        while (busy === 1'b1 && cyc - t0 < 2200) @(negedge clk);
        check("busy_len", 64'(cyc - t0), 2080);
        step(5);
        check("done_busy", busy, 0);
        check("done_tx", tx, 1);
        check("done_count", count, 10);
        halt = 1'b0;
        step(2);
        check("rearm_count", count, 0);

        // halt straight from IDLE
        halt = 1'b1;
        expect_msg("msg_imm", "0x000000000\015\012", t0);
        wait_idle();
        halt = 1'b0;
        step(2);

        // halt and run wiggling during SEND
        run = 1'b1;
        step(5);
        run = 1'b0;
        halt = 1'b1;
        fork
            expect_msg("msg_tog", "0x000000005\015\012", t0);
            begin
                step(3);
                for (int k = 0; k < 60; k++) begin
                    halt = k[0];
                    run  = k[1];
                    step(17);
                end
                halt = 1'b1;
                run  = 1'b0;
                check("tog_count", count, 5);
            end
        join
        wait_idle();
        step(3);
        check("tog_done_count", count, 5);
        step(200);
        check("tog_single_busy", busy, 0);
        check("tog_single_tx", tx, 1);
        halt = 1'b0;
        step(2);
        check("tog_rearm_count", count, 0);

        // reset in the middle of the third byte
        run = 1'b1;
        step(3);
        run = 1'b0;
        halt = 1'b1;
        begin
            int n;
            n = 0;
            while (tx !== 1'b0 && n < 400) begin
                @(negedge clk);
                n++;
            end
            check("abort_start", 64'(n < 400), 1);
        end
        step(360);
        reset = 1'b1;
        halt = 1'b0;
        @(negedge clk);
        check("abort_tx", tx, 1);
        check("abort_busy", busy, 0);
        check("abort_count", count, 0);
        reset = 1'b0;
        step(2);
        check("abort_idle_tx", tx, 1);
        run = 1'b1;
        step(7);
        run = 1'b0;
        halt = 1'b1;
        expect_msg("msg_abort", "0x000000007\015\012", t0);
        wait_idle();
        halt = 1'b0;
        step(2);

        // 8-bit counter saturation
        sel8 = 1'b1;
        run8 = 1'b1;
        step(300);
        run8 = 1'b0;
        check("sat_count", count8, 8'hFF);
        check("sat_ovf", ovf8, 1);
        halt8 = 1'b1;
        @(negedge clk);
        check("sat_busy", busy8, 1);
        expect_msg("msg_sat", "0xFF\015\012", t0);
        wait_idle();
        halt8 = 1'b0;
        step(2);
        check("sat_rearm_count", count8, 0);
        check("sat_ovf_kept", ovf8, 1);
        check("wide_no_ovf", overflow, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/bb_result_uart.md
BB_RESULT_UART -- requirements
Module: bb_result_uart

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 66000000, meaning the input clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 115200, meaning the UART bit rate.
REQ-003 The block SHALL have parameter CNT_W, default 36, meaning the step-counter width; it SHALL be a multiple of 4.
REQ-004 The block SHALL have port CLK_66MHZ, input, 1 bit: the single clock.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port run, input, 1 bit: the upstream Turing machine executed a step this cycle (machine in state A or B).
REQ-007 The block SHALL have port halt, input, 1 bit: the upstream machine is in its halt state.
REQ-008 The block SHALL have port tx, output, 1 bit: UART serial line, 8N1, idle high.
REQ-009 The block SHALL have port busy, output, 1 bit: a report is being transmitted.
REQ-010 The block SHALL have port count, output, CNT_W bits: the live step count.
REQ-011 The block SHALL have port overflow, output, 1 bit: the counter has saturated.

Function
REQ-012 The FSM SHALL have four states: IDLE, COUNT, SEND and DONE.
REQ-013 IDLE -> COUNT on the first cycle with run=1 and halt=0; count SHALL increment on that same cycle.
REQ-014 In COUNT, count SHALL increment by 1 on each cycle with run=1 and halt=0, and hold otherwise.
REQ-015 On reaching all-ones, count SHALL saturate and overflow SHALL be set; overflow SHALL stay set until reset.
REQ-016 A halt rising edge (halt=1, previous-cycle halt=0) in IDLE or COUNT SHALL latch count into a snapshot register and enter SEND on the next cycle.
REQ-017 On a halt rising edge, count SHALL NOT increment that cycle.
REQ-018 A halt rising edge in IDLE SHALL report a count of 0.
REQ-019 The SEND message SHALL be ASCII "0x", then CNT_W/4 uppercase hex digits MSB-first with leading zeros kept, then 0x0D and 0x0A (13 bytes at default width).
REQ-020 Each frame SHALL consist of 1 start bit (0), 8 data bits LSB-first and 1 stop bit (1).
REQ-021 Each bit SHALL last DIV = floor(CLK_HZ/BAUD) cycles (572 at defaults), and frames SHALL be sent back-to-back.
REQ-022 busy SHALL be 1 from the first cycle of SEND until the end of the last stop bit.
REQ-023 The SEND -> DONE transition SHALL occur on the cycle the last stop bit ends.
REQ-024 halt and run changes during SEND SHALL be ignored; count SHALL hold and the message SHALL be unaffected.
REQ-025 DONE SHALL -> IDLE when halt=0 (upstream re-armed), clearing count, while keeping overflow.
REQ-026 If halt is already 0 when SEND ends, DONE SHALL still last exactly one cycle.

Reset
REQ-027 While reset=1, on the next clock the block SHALL set state=IDLE, count=0, overflow=0, tx=1 and busy=0, clear the baud counter, and clear the halt-edge register to 0.
REQ-028 Reset during SEND SHALL abort the frame, with tx=1 on the following cycle and no partial byte resumed.

Structure
REQ-029 Package bb_pkg SHALL hold the FSM state enum and the ASCII constants ('0', 'x', 'A', CR, LF).
REQ-030 A single sub-module, uart_tx_byte, SHALL implement the byte serializer with DIV as a parameter and a valid/ready handshake; a byte SHALL be accepted only when valid=1 and ready=1.
REQ-031 The top level SHALL hold the counter, snapshot, halt-edge register, message sequencer and nibble-to-ASCII conversion.

Verification
REQ-032 Reset: hold reset 3 cycles -> tx=1, busy=0, count=0, overflow=0.
REQ-033 Run: CLK_HZ=16, BAUD=1, run=1 for 10 cycles then halt=1 -> count=10; tx bytes 30 78 30x8 41 0D 0A; each bit 16 cycles; busy low after 13x10x16 cycles.
REQ-034 Immediate halt: halt rising edge in IDLE -> message "0x000000000" CR LF.
REQ-035 Saturation: CNT_W=8, run for 300 cycles -> count=255, overflow=1; on halt the message is "0xFF" CR LF.
REQ-036 Halt during SEND: toggle halt 0/1 and pulse run -> a single unchanged message, count constant; after the message, halt=0 -> IDLE, count=0.
REQ-037 Abort: reset asserted during the 3rd byte's data bits -> tx=1 and busy=0 on the next cycle; the next run+halt sequence transmits a full, correct message.
